// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer.
// Steps the encryption through the initial AddRoundKey and then ten rounds of
// SubBytes, ShiftRows, MixColumns and AddRoundKey. Each stage gets a one-cycle
// enable and the FSM waits for that stage's done. A stalled stage times out
// after 15 cycles. abort_i cancels the sequence and returns to IDLE.
module aes_round_ctrl (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       ready_o,
  output logic       sb_en_o,
  output logic       sr_en_o,
  output logic       mc_en_o,
  output logic       ark_en_o,
  input  logic       sb_done_i,
  input  logic       sr_done_i,
  input  logic       mc_done_i,
  input  logic       ark_done_i,
  output logic       last_round_o,
  output logic [3:0] round_o,
  output logic       done_o,
  output logic       error_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT_ARK = 3'd1,
    S_SUB      = 3'd2,
    S_SHIFT    = 3'd3,
    S_MIX      = 3'd4,
    S_ADD      = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [3:0] TMO_LIMIT  = 4'd15;

  state_t     r_state;
  state_t     w_next;
  logic       r_first;     // high in the enable cycle of a stage state
  logic [3:0] r_cnt;       // cycles spent in the current stage
  logic [3:0] r_round;
  logic       w_in_stage;
  logic       w_stage_done;
  logic       w_done_ok;
  logic       w_tmo;

  // Next-state decode, done selection for the current stage, and timeout detection
  always_comb begin
    w_next       = r_state;
    w_in_stage   = 1'b0;
    w_stage_done = 1'b0;
    case (r_state)
      S_INIT_ARK: begin w_in_stage = 1'b1; w_stage_done = ark_done_i; end
      S_SUB:      begin w_in_stage = 1'b1; w_stage_done = sb_done_i;  end
      S_SHIFT:    begin w_in_stage = 1'b1; w_stage_done = sr_done_i;  end
      S_MIX:      begin w_in_stage = 1'b1; w_stage_done = mc_done_i;  end
      S_ADD:      begin w_in_stage = 1'b1; w_stage_done = ark_done_i; end
      default:    begin w_in_stage = 1'b0; w_stage_done = 1'b0;       end
    endcase

    // done is only honoured after the enable cycle
    w_done_ok = w_in_stage && !r_first && w_stage_done;
    w_tmo     = w_in_stage && !r_first && !w_stage_done && (r_cnt == TMO_LIMIT);

    case (r_state)
      S_IDLE: begin
        if (start_i) w_next = S_INIT_ARK;
      end
      S_INIT_ARK: begin
        if (w_done_ok)  w_next = S_SUB;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_SUB: begin
        if (w_done_ok)  w_next = S_SHIFT;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_SHIFT: begin
        if (w_done_ok)  w_next = S_MIX;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_MIX: begin
        if (w_done_ok)  w_next = S_ADD;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_ADD: begin
        if (w_done_ok)  w_next = (r_round == LAST_ROUND) ? S_DONE : S_SUB;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // abort outranks every other transition
    if (abort_i && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // State register plus enable-cycle flag and stage timeout counter
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_first <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_first <= 1'b1;
        r_cnt   <= 4'd0;
      end else begin
        r_first <= 1'b0;
        if (w_in_stage && (r_cnt != TMO_LIMIT)) r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Round counter: 1 after the initial key add, +1 per completed round, 0 in IDLE
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_round <= 4'd0;
    end else if (w_next == S_IDLE) begin
      r_round <= 4'd0;
    end else if ((r_state == S_INIT_ARK) && (w_next == S_SUB)) begin
      r_round <= 4'd1;
    end else if ((r_state == S_ADD) && (w_next == S_SUB)) begin
      r_round <= r_round + 4'd1;
    end
  end

  // Output decode; the final round skips MixColumns but still waits for its done
  always_comb begin
    ready_o      = (r_state == S_IDLE);
    sb_en_o      = r_first && (r_state == S_SUB);
    sr_en_o      = r_first && (r_state == S_SHIFT);
    mc_en_o      = r_first && (r_state == S_MIX) && (r_round != LAST_ROUND);
    ark_en_o     = r_first && ((r_state == S_INIT_ARK) || (r_state == S_ADD));
    last_round_o = (r_round == LAST_ROUND);
    round_o      = r_round;
    done_o       = (r_state == S_DONE) && !abort_i;
    error_o      = w_tmo && !abort_i;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed testbench for aes_round_ctrl with a stage responder that answers
// each enable with a done one cycle later.
module tb_aes_round_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic       start_i, abort_i;
  logic       ready_o;
  logic       sb_en_o, sr_en_o, mc_en_o, ark_en_o;
  logic       sb_done_i, sr_done_i, mc_done_i, ark_done_i;
  logic       last_round_o;
  logic [3:0] round_o;
  logic       done_o, error_o;

  aes_round_ctrl dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .ready_o(ready_o),
    .sb_en_o(sb_en_o), .sr_en_o(sr_en_o), .mc_en_o(mc_en_o), .ark_en_o(ark_en_o),
    .sb_done_i(sb_done_i), .sr_done_i(sr_done_i), .mc_done_i(mc_done_i),
    .ark_done_i(ark_done_i),
    .last_round_o(last_round_o), .round_o(round_o),
    .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // cycle counter and per-run statistics
  int cyc = 0;
  int c0 = 0;
  int n_sb, n_sr, n_mc, n_ark, n_done, n_err, mc_last, ark_last;
  int done_cyc, err_cyc, sr3_cyc, round_at_done;
  bit mix5;
  bit hold_sr3, abort_mode, stray_mode;

  always @(posedge clk_i) cyc = cyc + 1;

  task automatic clear_stats();
    n_sb = 0; n_sr = 0; n_mc = 0; n_ark = 0; n_done = 0; n_err = 0;
    mc_last = 0; ark_last = 0; done_cyc = -1; err_cyc = -1; sr3_cyc = -1;
    round_at_done = -1; mix5 = 0;
  endtask

  always @(negedge clk_i) begin
    if (sb_en_o)  n_sb++;
    if (sr_en_o)  n_sr++;
    if (mc_en_o)  n_mc++;
    if (ark_en_o) n_ark++;
    if (mc_en_o && last_round_o)  mc_last++;
    if (ark_en_o && last_round_o) ark_last++;
    if (sr_en_o && round_o == 4'd3) sr3_cyc = cyc;
    if (mc_en_o && round_o == 4'd5) mix5 = 1'b1;
    if (done_o) begin n_done++; done_cyc = cyc - c0 + 1; round_at_done = int'(round_o); end
    if (error_o) begin n_err++; err_cyc = cyc; end
  end

  // Stage responder: done one cycle after each enable; round-10 MIX has no
  // enable, so its done is scheduled from the round-10 ShiftRows completion.
  initial begin
    logic c_sb, c_sr, c_mc, c_ark;
    int   mix_pend;
    sb_done_i = 0; sr_done_i = 0; mc_done_i = 0; ark_done_i = 0; abort_i = 0;
    mix_pend = 0;
    forever begin
      @(negedge clk_i);
      c_sb = sb_en_o; c_sr = sr_en_o; c_mc = mc_en_o; c_ark = ark_en_o;
      if (mix_pend == 1) c_mc = 1'b1;
      if (mix_pend > 0) mix_pend--;
      if (!rst_n) begin c_sb = 0; c_sr = 0; c_mc = 0; c_ark = 0; mix_pend = 0; end
      @(posedge clk_i);
      #1;
      sb_done_i  = c_sb;
      sr_done_i  = c_sr && !(hold_sr3 && round_o == 4'd3);
      mc_done_i  = c_mc || (stray_mode && c_sb);
      ark_done_i = c_ark;
      abort_i    = abort_mode && c_ark && last_round_o;
      if (sr_done_i && last_round_o) mix_pend = 2;
    end
  end

  task automatic start_pulse();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 c0 = cyc; start_i = 1'b0;
  endtask

  task automatic wait_ready(input int bound);
    bit hit = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (ready_o) begin hit = 1; break; end
    end
    #1;
    chk("wait_ready", int'(hit), 1);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0;
    hold_sr3 = 0; abort_mode = 0; stray_mode = 0;
    clear_stats();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_round", int'(round_o), 0);
    chk("rst_last", int'(last_round_o), 0);
    chk("rst_en", int'({sb_en_o, sr_en_o, mc_en_o, ark_en_o}), 0);
    chk("rst_done_err", int'({done_o, error_o}), 0);
    @(negedge clk_i) rst_n = 1'b1;

    // nominal sequence
    clear_stats();
    start_pulse();
    wait_ready(200);
    chk("nom_done_cyc", done_cyc, 83);
    chk("nom_n_done", n_done, 1);
    chk("nom_sb", n_sb, 10);
    chk("nom_sr", n_sr, 10);
    chk("nom_mc", n_mc, 9);
    chk("nom_ark", n_ark, 11);
    chk("nom_round_done", round_at_done, 10);
    chk("nom_mc_last", mc_last, 0);
    chk("nom_ark_last", ark_last, 1);
    chk("nom_err", n_err, 0);
    chk("nom_round_idle", int'(round_o), 0);

    // timeout on ShiftRows in round 3
    clear_stats();
    hold_sr3 = 1;
    start_pulse();
    wait_ready(200);
    hold_sr3 = 0;
    chk("tmo_delay", err_cyc - sr3_cyc, 15);
    chk("tmo_n_err", n_err, 1);
    chk("tmo_n_done", n_done, 0);
    chk("tmo_ready", int'(ready_o), 1);
    chk("tmo_round", int'(round_o), 0);

    // abort together with ark_done in round 10 ADD
    clear_stats();
    abort_mode = 1;
    start_pulse();
    wait_ready(200);
    abort_mode = 0;
    repeat (3) @(negedge clk_i);
    chk("abt_ark_last", ark_last, 1);
    chk("abt_n_done", n_done, 0);
    chk("abt_n_err", n_err, 0);
    chk("abt_round", int'(round_o), 0);

    // start held high plus stray mc_done during SUB
    clear_stats();
    stray_mode = 1;
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 c0 = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i); #1;
      if (n_done > 0) break;
    end
    start_i = 1'b0;
    wait_ready(20);
    stray_mode = 0;
    repeat (3) @(negedge clk_i);
    chk("rob_done_cyc", done_cyc, 83);
    chk("rob_n_done", n_done, 1);
    chk("rob_mc", n_mc, 9);
    chk("rob_sb", n_sb, 10);
    chk("rob_idle", int'(ready_o), 1);

    // asynchronous reset during round 5 MIX
    clear_stats();
    start_pulse();
    begin
      bit hit = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk_i); #1;
        if (mix5) begin hit = 1; break; end
      end
      chk("rst5_reached", int'(hit), 1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst5_ready", int'(ready_o), 1);
    chk("rst5_round", int'(round_o), 0);
    chk("rst5_en", int'({sb_en_o, sr_en_o, mc_en_o, ark_en_o}), 0);
    chk("rst5_done_err", int'({done_o, error_o}), 0);
    repeat (2) @(negedge clk_i);
    chk("rst5_no_done", n_done + n_err, 0);
    rst_n = 1'b1;
    clear_stats();
    start_pulse();
    wait_ready(200);
    chk("rst5_done_cyc", done_cyc, 83);
    chk("rst5_n_done", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
